// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register indices, bit positions and exception codes
package cp0_pkg;

   // CP0 register indices as seen on Addr
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_SR       = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_PRID     = 5'd15;

   // SR and Cause bit positions
   localparam int SR_IE      = 0;
   localparam int SR_EXL     = 1;
   localparam int CAUSE_BD   = 31;
   localparam int IP_HI      = 15;
   localparam int IP_LO      = 10;
   localparam int EXC_HI     = 6;
   localparam int EXC_LO     = 2;

   // Exception codes
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Assemble the Cause register image from its stored fields
   function automatic logic [31:0] pack_cause(input logic bd,
                                              input logic [5:0] ip,
                                              input logic [4:0] code);
      logic [31:0] c;
      c = '0;
      c[CAUSE_BD]       = bd;
      c[IP_HI:IP_LO]    = ip;
      c[EXC_HI:EXC_LO]  = code;
      return c;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler and sticky match flag
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int COUNT_DIV = 1,
   parameter bit TIMER_EN  = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        count_we_i,
   input  logic        compare_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_pend_o
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0] div_q,     div_d;
   logic [31:0]      count_q,   count_d;
   logic [31:0]      compare_q, compare_d;
   logic             pend_q,    pend_d;
   logic             tick;
   logic             match;

   assign tick  = (div_q == DIV_LAST);
   assign match = TIMER_EN && (count_q == compare_q);

   // Next-state: software writes override the prescaled increment
   always_comb begin
      div_d     = div_q;
      count_d   = count_q;
      compare_d = compare_q;
      pend_d    = pend_q;
      if (count_we_i) begin
         count_d = wdata_i;
         div_d   = '0;
      end else if (tick) begin
         count_d = count_q + 32'd1;
         div_d   = '0;
      end else begin
         div_d   = div_q + DIV_W'(1);
      end
      if (compare_we_i) begin
         compare_d = wdata_i;
         pend_d    = 1'b0;
      end else if (match) begin
         pend_d    = 1'b1;
      end
   end

   // Timer state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
      end
   end

   assign count_o      = count_q;
   assign compare_o    = compare_q;
   assign timer_pend_o = TIMER_EN ? pend_q : 1'b0;

endmodule

// File: rtl/cp0_ext.sv
// rtl/cp0_ext.sv - CP0 exception/interrupt controller with ERET and fetch redirect
module cp0_ext
   import cp0_pkg::*;
#(
   parameter int          NUM_HWINT  = 6,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter logic [31:0] PRID_VALUE = 32'h0000_0000,
   parameter int          COUNT_DIV  = 1,
   parameter bit          TIMER_EN   = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [4:0]           Addr,
   input  logic [31:0]          WData,
   input  logic                 CPWrite,
   input  logic [31:0]          PC_F,
   input  logic [31:0]          nPCAlt_in,
   input  logic                 nPCSel_in,
   input  logic [4:0]           ExcCode,
   input  logic [31:0]          BadVAddr_in,
   input  logic [NUM_HWINT-1:0] HWInt,
   input  logic                 ERet,
   output logic [31:0]          nPCAlt,
   output logic                 nPCSel,
   output logic [31:0]          RData,
   output logic                 ExcStall,
   output logic                 TimerIrq
);

   logic [31:0] sr_q,       sr_d;
   logic [31:0] epc_q,      epc_d;
   logic [31:0] badv_q,     badv_d;
   logic        cause_bd_q, cause_bd_d;
   logic [5:0]  cause_ip_q, cause_ip_d;
   logic [4:0]  cause_ec_q, cause_ec_d;

   logic [5:0]  ext;
   logic [5:0]  ip;
   logic        exc;
   logic        wr_ok;
   logic        timer_pend;
   logic [31:0] count_val;
   logic [31:0] compare_val;

   // Zero-extend the external lines to the full six-bit IP field
   always_comb begin
      ext = '0;
      ext[NUM_HWINT-1:0] = HWInt;
   end

   assign ip    = {timer_pend | ext[5], ext[4:0]};
   assign exc   = ((|(ip & sr_q[IP_HI:IP_LO])) | (ExcCode != EXC_INT))
                  & ~sr_q[SR_EXL] & sr_q[SR_IE];
   // Software writes lose to any exception or ERET in the same cycle
   assign wr_ok = CPWrite & ~exc & ~ERet;

   cp0_timer #(
      .COUNT_DIV (COUNT_DIV),
      .TIMER_EN  (TIMER_EN)
   ) u_timer (
      .clk_i        (Clk),
      .rst_i        (Rst),
      .count_we_i   (wr_ok && (Addr == CP0_COUNT)),
      .compare_we_i (wr_ok && (Addr == CP0_COMPARE)),
      .wdata_i      (WData),
      .count_o      (count_val),
      .compare_o    (compare_val),
      .timer_pend_o (timer_pend)
   );

   // Fetch redirect: exception entry beats ERET beats the pipeline's own override
   always_comb begin
      nPCAlt   = nPCAlt_in;
      nPCSel   = nPCSel_in;
      ExcStall = 1'b0;
      if (exc) begin
         nPCAlt   = EXC_VECTOR;
         nPCSel   = 1'b1;
         ExcStall = 1'b1;
      end else if (ERet) begin
         nPCAlt   = epc_q;
         nPCSel   = 1'b1;
         ExcStall = 1'b1;
      end
   end

   // Register next-state: exception entry, ERET, then MTC0
   always_comb begin
      sr_d       = sr_q;
      epc_d      = epc_q;
      badv_d     = badv_q;
      cause_bd_d = cause_bd_q;
      cause_ip_d = ip;
      cause_ec_d = cause_ec_q;
      if (exc) begin
         // A delay-slot victim restarts at its branch, one word earlier
         epc_d          = nPCSel_in ? (PC_F - 32'd4) : PC_F;
         cause_bd_d     = nPCSel_in;
         sr_d[SR_EXL]   = 1'b1;
         cause_ec_d     = ExcCode;
         if ((ExcCode == EXC_ADEL) || (ExcCode == EXC_ADES)) begin
            badv_d = BadVAddr_in;
         end
      end else if (ERet) begin
         sr_d[SR_EXL] = 1'b0;
      end else if (CPWrite) begin
         case (Addr)
            CP0_SR:  sr_d  = WData;
            CP0_EPC: epc_d = WData;
            default: ;
         endcase
      end
   end

   // Architectural registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sr_q       <= '0;
         epc_q      <= '0;
         badv_q     <= '0;
         cause_bd_q <= 1'b0;
         cause_ip_q <= '0;
         cause_ec_q <= '0;
      end else begin
         sr_q       <= sr_d;
         epc_q      <= epc_d;
         badv_q     <= badv_d;
         cause_bd_q <= cause_bd_d;
         cause_ip_q <= cause_ip_d;
         cause_ec_q <= cause_ec_d;
      end
   end

   // MFC0 read mux
   always_comb begin
      RData = '0;
      case (Addr)
         CP0_BADVADDR: RData = badv_q;
         CP0_COUNT:    RData = count_val;
         CP0_COMPARE:  RData = compare_val;
         CP0_SR:       RData = sr_q;
         CP0_CAUSE:    RData = pack_cause(cause_bd_q, cause_ip_q, cause_ec_q);
         CP0_EPC:      RData = epc_q;
         CP0_PRID:     RData = PRID_VALUE;
         default:      RData = '0;
      endcase
   end

   assign TimerIrq = timer_pend;

endmodule

// File: tb/tb_cp0_ext.sv
// tb/tb_cp0_ext.sv - directed self-checking bench for cp0_ext
module tb_cp0_ext;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [4:0]  Addr;
   logic [31:0] WData;
   logic        CPWrite;
   logic [31:0] PC_F;
   logic [31:0] nPCAlt_in;
   logic        nPCSel_in;
   logic [4:0]  ExcCode;
   logic [31:0] BadVAddr_in;
   logic [5:0]  HWInt;
   logic        ERet;
   logic [31:0] nPCAlt;
   logic        nPCSel;
   logic [31:0] RData;
   logic        ExcStall;
   logic        TimerIrq;

   int checks = 0;
   int errors = 0;

   cp0_ext #(
      .NUM_HWINT  (6),
      .EXC_VECTOR (32'h0000_4180),
      .PRID_VALUE (32'h0000_ABCD),
      .COUNT_DIV  (1),
      .TIMER_EN   (1'b1)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Addr        (Addr),
      .WData       (WData),
      .CPWrite     (CPWrite),
      .PC_F        (PC_F),
      .nPCAlt_in   (nPCAlt_in),
      .nPCSel_in   (nPCSel_in),
      .ExcCode     (ExcCode),
      .BadVAddr_in (BadVAddr_in),
      .HWInt       (HWInt),
      .ERet        (ERet),
      .nPCAlt      (nPCAlt),
      .nPCSel      (nPCSel),
      .RData       (RData),
      .ExcStall    (ExcStall),
      .TimerIrq    (TimerIrq)
   );

   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
      Addr = a;
      #1;
      chk(tag, RData, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      Addr    = a;
      WData   = d;
      CPWrite = 1'b1;
      tick();
      CPWrite = 1'b0;
      WData   = '0;
   endtask

   initial begin
      Rst = 1'b1; Addr = '0; WData = '0; CPWrite = 1'b0; PC_F = '0;
      nPCAlt_in = '0; nPCSel_in = 1'b0; ExcCode = '0; BadVAddr_in = '0;
      HWInt = '0; ERet = 1'b0;
      tick();
      tick();
      Rst = 1'b0;

      // Reset state and pass-through
      nPCSel_in = 1'b1; nPCAlt_in = 32'h0000_5000;
      #1;
      chk("rst_npcsel",   {31'd0, nPCSel}, 32'd1);
      chk("rst_npcalt",   nPCAlt, 32'h0000_5000);
      chk("rst_excstall", {31'd0, ExcStall}, 32'd0);
      chk("rst_timerirq", {31'd0, TimerIrq}, 32'd0);
      chk_reg("rst_sr",    5'd12, 32'd0);
      chk_reg("rst_cause", 5'd13, 32'd0);
      chk_reg("rst_epc",   5'd14, 32'd0);
      chk_reg("rst_badv",  5'd8,  32'd0);
      chk_reg("rst_cmp",   5'd11, 32'd0);
      chk_reg("prid",      5'd15, 32'h0000_ABCD);
      chk_reg("unmapped",  5'd10, 32'd0);
      nPCSel_in = 1'b0; nPCAlt_in = '0;

      // Park Compare far away so the reset-time Count==Compare match is cleared
      mtc0(5'd11, 32'h8000_0000);
      chk("t1_timer_clear", {31'd0, TimerIrq}, 32'd0);

      // Test 1: external interrupt on line 2
      mtc0(5'd12, 32'h0000_FC01);
      HWInt = 6'b000100; PC_F = 32'h0000_3010; nPCSel_in = 1'b0;
      #1;
      chk("t1_npcalt",   nPCAlt, 32'h0000_4180);
      chk("t1_npcsel",   {31'd0, nPCSel}, 32'd1);
      chk("t1_excstall", {31'd0, ExcStall}, 32'd1);
      tick();
      HWInt = '0;
      chk_reg("t1_epc",   5'd14, 32'h0000_3010);
      chk_reg("t1_cause", 5'd13, 32'h0000_1000);
      chk_reg("t1_sr",    5'd12, 32'h0000_FC03);

      // ERET back out, then an AdEL in a delay slot
      ERet = 1'b1;
      #1;
      chk("t2_eret_npcalt", nPCAlt, 32'h0000_3010);
      chk("t2_eret_stall",  {31'd0, ExcStall}, 32'd1);
      tick();
      ERet = 1'b0;
      chk_reg("t2_sr_after_eret", 5'd12, 32'h0000_FC01);
      ExcCode = 5'd4; BadVAddr_in = 32'h0000_1003; PC_F = 32'h0000_3024;
      nPCSel_in = 1'b1; nPCAlt_in = 32'h0000_7000;
      #1;
      chk("t2_stall",  {31'd0, ExcStall}, 32'd1);
      chk("t2_npcalt", nPCAlt, 32'h0000_4180);
      tick();
      ExcCode = '0; BadVAddr_in = '0; nPCSel_in = 1'b0; nPCAlt_in = '0;
      chk_reg("t2_epc",   5'd14, 32'h0000_3020);
      chk_reg("t2_cause", 5'd13, 32'h8000_0010);
      chk_reg("t2_badv",  5'd8,  32'h0000_1003);

      // Test 3: interrupt held while EXL=1, taken after ERET
      HWInt = 6'b000001;
      #1;
      chk("t3_no_redirect", {31'd0, ExcStall}, 32'd0);
      chk("t3_npcsel",      {31'd0, nPCSel}, 32'd0);
      tick();
      chk_reg("t3_cause_live", 5'd13, 32'h8000_0410);
      ERet = 1'b1;
      #1;
      chk("t3_eret_npcalt", nPCAlt, 32'h0000_3020);
      tick();
      ERet = 1'b0;
      chk_reg("t3_sr_exl0", 5'd12, 32'h0000_FC01);
      PC_F = 32'h0000_3100;
      #1;
      chk("t3_taken_stall", {31'd0, ExcStall}, 32'd1);
      chk("t3_taken_npc",   nPCAlt, 32'h0000_4180);
      tick();
      HWInt = '0;
      chk_reg("t3_epc",   5'd14, 32'h0000_3100);
      chk_reg("t3_cause", 5'd13, 32'h0000_0400);

      // Test 4: timer interrupt, Count=0, Compare=5
      mtc0(5'd9,  32'd0);
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h0000_8001);
      chk("t4_irq_early", {31'd0, TimerIrq}, 32'd0);
      tick();
      tick();
      tick();
      chk("t4_irq_still0",   {31'd0, TimerIrq}, 32'd0);
      chk("t4_stall_still0", {31'd0, ExcStall}, 32'd0);
      PC_F = 32'h0000_3200;
      tick();
      chk("t4_irq_set",  {31'd0, TimerIrq}, 32'd1);
      chk("t4_stall",    {31'd0, ExcStall}, 32'd1);
      chk("t4_npcalt",   nPCAlt, 32'h0000_4180);
      tick();
      chk_reg("t4_epc",   5'd14, 32'h0000_3200);
      chk_reg("t4_cause", 5'd13, 32'h0000_8000);
      chk_reg("t4_count", 5'd9,  32'd7);
      mtc0(5'd11, 32'd100);
      chk("t4_irq_cleared", {31'd0, TimerIrq}, 32'd0);

      // Test 5: Count wrap and match just past zero
      mtc0(5'd9,  32'hFFFF_FFFE);
      mtc0(5'd11, 32'd1);
      chk_reg("t5_count_ff", 5'd9, 32'hFFFF_FFFF);
      tick();
      chk_reg("t5_count_wrap", 5'd9, 32'd0);
      chk("t5_irq0", {31'd0, TimerIrq}, 32'd0);
      tick();
      chk_reg("t5_count_1", 5'd9, 32'd1);
      chk("t5_irq1", {31'd0, TimerIrq}, 32'd0);
      tick();
      chk("t5_irq_set", {31'd0, TimerIrq}, 32'd1);

      // Test 6a: MTC0 SR dropped when it collides with an exception
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      Addr = 5'd12; WData = 32'd0; CPWrite = 1'b1; PC_F = 32'h0000_3300;
      #1;
      chk("t6_stall", {31'd0, ExcStall}, 32'd1);
      tick();
      CPWrite = 1'b0;
      chk_reg("t6_sr_kept", 5'd12, 32'h0000_8003);
      chk_reg("t6_epc",     5'd14, 32'h0000_3300);

      // Test 6b: reset wins over a simultaneous exception
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      Rst = 1'b1; PC_F = 32'h0000_3400;
      #1;
      chk("t6_rst_stall", {31'd0, ExcStall}, 32'd1);
      tick();
      Rst = 1'b0;
      chk_reg("t6_rst_sr",    5'd12, 32'd0);
      chk_reg("t6_rst_epc",   5'd14, 32'd0);
      chk_reg("t6_rst_cause", 5'd13, 32'd0);
      chk_reg("t6_rst_count", 5'd9,  32'd0);
      chk_reg("t6_rst_cmp",   5'd11, 32'd0);
      chk_reg("t6_rst_badv",  5'd8,  32'd0);
      chk("t6_rst_irq", {31'd0, TimerIrq}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_ext.md
Name: cp0_ext

Overview:
Parametrised successor to the coprocessor-0 exception controller in the MIPS pipeline. Owns the SR, Cause, EPC, PRId, BadVAddr, Count and Compare registers, and arbitrates exceptions, interrupts and ERET. Produces the next-PC override for the fetch stage. Adds an internal Count/Compare timer whose interrupt is wired to the highest interrupt line, and makes the vector, PRId and interrupt-line count configurable.

Parameters:
NUM_HWINT, 6, external hardware interrupt lines (1..6); Cause.IP[15:10] bits above NUM_HWINT read as 0
EXC_VECTOR, 32'h0000_4180, exception/interrupt entry PC
PRID_VALUE, 32'h0000_0000, read-only PRId contents
COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (1..16)
TIMER_EN, 1, 1 = timer drives IP[15] (OR'd with external line 5 if present); 0 = timer logic tied off

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
Addr  in  5  CP0 register index (8,9,11,12,13,14,15)
WData  in  32  MTC0 write data
CPWrite  in  1  MTC0 write strobe
PC_F  in  32  PC of the instruction being preempted
nPCAlt_in  in  32  pipeline next-PC override (branch/jump)
nPCSel_in  in  1  pipeline override valid; 1 = preempted instruction is in a delay slot
ExcCode  in  5  synchronous exception code, 0 = none
BadVAddr_in  in  32  faulting address, captured when ExcCode is 4 or 5
HWInt  in  NUM_HWINT  external interrupt requests, level-sensitive
ERet  in  1  ERET in the commit stage
nPCAlt  out  32  next-PC override to fetch
nPCSel  out  1  override valid
RData  out  32  MFC0 read data (combinational on Addr)
ExcStall  out  1  flush/stall pipeline this cycle
TimerIrq  out  1  timer pending flag (debug/observe)

Behaviour:
- Reset (synchronous, Rst=1 at posedge): SR, Cause, EPC, BadVAddr, Count, Compare, timer-pending and the divider counter all go to 0. Outputs track their combinational sources, so nPCSel=nPCSel_in and ExcStall=0 when there is no other request.
- ip = {timer_pend | ext[5], ext[4:0]}, where ext is HWInt zero-extended to 6 bits.
- Exc = (|(ip & SR[15:10]) | (ExcCode != 0)) & !SR.EXL & SR.IE. Purely combinational.
- Redirect, combinational, priority Exc > ERet > pass-through:
  - Exc: nPCAlt=EXC_VECTOR, nPCSel=1, ExcStall=1.
  - ERet: nPCAlt=EPC, nPCSel=1, ExcStall=1.
  - Otherwise: nPCAlt/nPCSel follow the inputs and ExcStall=0.
- Register update at posedge, priority Rst > Exc > ERet > CPWrite:
  - Exc:
    - If nPCSel_in: EPC<=PC_F-4 and Cause.BD<=1. Else: EPC<=PC_F and Cause.BD<=0.
    - SR.EXL<=1, Cause[15:10]<=ip, Cause[6:2]<=ExcCode.
    - If ExcCode is 4 or 5: BadVAddr<=BadVAddr_in.
  - ERet: SR.EXL<=0.
  - CPWrite:
    - Addr 12: SR<=WData.
    - Addr 14: EPC<=WData.
    - Addr 9: Count<=WData.
    - Addr 11: Compare<=WData and timer_pend<=0.
    - Other addresses are ignored. Cause, PRId and BadVAddr are read-only.
  - A CPWrite in the same cycle as Exc or ERet is dropped.
- Cause.IP[15:10] also samples ip every cycle while there is no Exc, so software sees live pending state.
- Timer:
  - The divider counts 0..COUNT_DIV-1. Count increments with 32-bit wrap on each terminal count.
  - An MTC0 to Count reloads Count and clears the divider in the same cycle. It overrides that cycle's increment.
  - timer_pend<=1 in the cycle after Count==Compare is first true (compared on the registered values while TIMER_EN=1). It stays set until an MTC0 to Compare or Rst.
  - The timer keeps counting while SR.EXL=1.
- RData: 8→BadVAddr, 9→Count, 11→Compare, 12→SR, 13→Cause, 14→EPC, 15→PRID_VALUE, other addresses→0.
- Boundaries:
  - Count wraps from 32'hFFFF_FFFF to 0, and a match at 0 fires normally.
  - Compare written equal to the current Count: the pending bit is cleared that cycle and sets again on the next match evaluation.
  - An interrupt that arrives with EXL=1 is held pending (level) and taken after ERet clears EXL.
  - Rst asserted in the same cycle as Exc: reset wins and EPC=0.

Decomposition:
- Shared package cp0_pkg holds:
  - register indices (CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15);
  - SR/Cause bit positions (IE=0, EXL=1, BD=31, IP field 15:10, ExcCode field 6:2);
  - ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
- One sub-module, cp0_timer, contains the divider, Count, Compare and timer_pend. Its interface is the write strobes, write data and timer_pend out.

Test Plan:
1. Rst, then MTC0 SR=32'h0000_FC01, HWInt[2]=1 with PC_F=32'h3010, nPCSel_in=0 → same cycle nPCAlt=32'h4180, nPCSel=1, ExcStall=1; next cycle EPC=32'h3010, Cause=32'h0000_1000, SR.EXL=1.
2. SR enabled, ExcCode=4, BadVAddr_in=32'h1003, PC_F=32'h3024, nPCSel_in=1 → EPC=32'h3020, Cause.BD=1, Cause[6:2]=4, BadVAddr=32'h1003.
3. EXL=1 and HWInt[0] held high → no redirect. ERet → nPCAlt=EPC and EXL=0. Next cycle the interrupt is taken.
4. COUNT_DIV=1, Count=0, Compare=5, SR=32'h0000_8001 → exception is taken 6 cycles after the Compare write. MTC0 Compare=100 clears TimerIrq.
5. Count written to 32'hFFFF_FFFE, Compare=1 → Count wraps to 0, TimerIrq sets after Count==1.
6. CPWrite to SR together with Exc → write dropped, SR.EXL=1, other SR bits unchanged. Rst together with Exc → all registers 0.
